// File: rtl/piso_shiftreg.sv
// Parallel-in, serial-out transmitter: valid/ready word load, LSB-first serial
// output with a so_valid flag and a done pulse. Define PISO_PARITY_EN to append an even-parity bit.
module piso_shiftreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             so,
  output logic             so_valid,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int FW = WIDTH + 1;
`else
  localparam int FW = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FW - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_nxt;
  logic [FW-1:0]   shreg;
  logic [FW-1:0]   frame;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            load;

`ifdef PISO_PARITY_EN
  // Parity sits above the data so it falls out after the MSB.
  assign frame = {^pi, pi};
`else
  assign frame = pi;
`endif

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    last      = (state == SHIFT) && (cnt == LAST);
    in_ready  = (state == IDLE) || last;
    load      = in_valid && in_ready;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (last && !load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      so       <= 1'b0;
      so_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= last;
      if (load) begin
        shreg    <= frame;
        cnt      <= '0;
        so       <= frame[0];
        so_valid <= 1'b1;
      end else if (state == SHIFT && !last) begin
        // shreg[0] is the bit on so now; shreg[1] is the next one.
        shreg    <= shreg >> 1;
        cnt      <= cnt + CW'(1);
        so       <= shreg[1];
        so_valid <= 1'b1;
      end else begin
        so       <= 1'b0;
        so_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piso_shiftreg.sv
// Bench for piso_shiftreg: fixed vector table, hand-written corner sequences,
// then random traffic checked against a bit-queue reference model.
module tb_piso_shiftreg;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] pi;
  logic             in_valid;
  logic             in_ready;
  logic             so;
  logic             so_valid;
  logic             done;

  piso_shiftreg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .pi(pi), .in_valid(in_valid),
    .in_ready(in_ready), .so(so), .so_valid(so_valid), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of frame bits still to appear on so; front is current.
  bit q[$];
  bit m_done = 1'b0;

  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] d;
    logic             e_so;
    logic             e_sov;
    logic             e_done;
    logic             e_rdy;
  } vec_t;

  vec_t tbl[35];

  function automatic vec_t mk(logic iv, logic [WIDTH-1:0] d,
                              logic s, logic v, logic dn, logic r);
    vec_t t;
    t.iv = iv; t.d = d; t.e_so = s; t.e_sov = v; t.e_done = dn; t.e_rdy = r;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(string tag, bit e_so, bit e_sov, bit e_done, bit e_rdy);
    check({tag, ".so"},       32'(so),       32'(e_so));
    check({tag, ".so_valid"}, 32'(so_valid), 32'(e_sov));
    check({tag, ".done"},     32'(done),     32'(e_done));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(e_rdy));
  endtask

  task automatic push_word(logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) q.push_back(w[i]);
`ifdef PISO_PARITY_EN
    q.push_back(^w);
`endif
  endtask

  // Ready whenever nothing is pending or only the final bit remains on so.
  task automatic model_edge(bit iv, logic [WIDTH-1:0] d);
    bit acc;
    acc    = iv && (q.size() <= 1);
    m_done = (q.size() == 1);
    if (q.size() > 0) void'(q.pop_front());
    if (acc) push_word(d);
  endtask

  task automatic model_check(string tag);
    bit e_so;
    e_so = (q.size() > 0) ? q[0] : 1'b0;
    check_outs(tag, e_so, q.size() > 0, m_done, q.size() <= 1);
  endtask

  task automatic cycle(string tag, bit iv, logic [WIDTH-1:0] d);
    in_valid = iv;
    pi       = d;
    @(posedge clk);
    model_edge(iv, d);
    #1;
    model_check(tag);
  endtask

  // Called 1 time unit after an edge; asserts rst mid-cycle with a word offered.
  task automatic async_reset();
    in_valid = 1'b1;
    pi       = WIDTH'($urandom);
    #2 rst = 1'b1;
    #1;
    q.delete();
    m_done = 1'b0;
    check_outs("rst_immediate", 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_outs("rst_held_edge", 1'b0, 1'b0, 1'b0, 1'b1);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] got;

    rst = 1'b1; in_valid = 1'b0; pi = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check_outs("post_release", 1'b0, 1'b0, 1'b0, 1'b1);

`ifndef PISO_PARITY_EN
    // A5 alone, 3C back-to-back behind it, then FF with ignored 00 requests.
    tbl[0]  = mk(1, 8'hA5, 1, 1, 0, 0);
    tbl[1]  = mk(0, 8'h00, 0, 1, 0, 0);
    tbl[2]  = mk(0, 8'h00, 1, 1, 0, 0);
    tbl[3]  = mk(0, 8'h00, 0, 1, 0, 0);
    tbl[4]  = mk(0, 8'h00, 0, 1, 0, 0);
    tbl[5]  = mk(0, 8'h00, 1, 1, 0, 0);
    tbl[6]  = mk(0, 8'h00, 0, 1, 0, 0);
    tbl[7]  = mk(0, 8'h00, 1, 1, 0, 1);
    tbl[8]  = mk(1, 8'h3C, 0, 1, 1, 0);
    tbl[9]  = mk(0, 8'h00, 0, 1, 0, 0);
    tbl[10] = mk(0, 8'h00, 1, 1, 0, 0);
    tbl[11] = mk(0, 8'h00, 1, 1, 0, 0);
    tbl[12] = mk(0, 8'h00, 1, 1, 0, 0);
    tbl[13] = mk(0, 8'h00, 1, 1, 0, 0);
    tbl[14] = mk(0, 8'h00, 0, 1, 0, 0);
    tbl[15] = mk(0, 8'h00, 0, 1, 0, 1);
    tbl[16] = mk(0, 8'h00, 0, 0, 1, 1);
    tbl[17] = mk(0, 8'h00, 0, 0, 0, 1);
    tbl[18] = mk(1, 8'hFF, 1, 1, 0, 0);
    for (int i = 19; i <= 24; i++) tbl[i] = mk(1, 8'h00, 1, 1, 0, 0);
    tbl[25] = mk(1, 8'h00, 1, 1, 0, 1);
    tbl[26] = mk(1, 8'h00, 0, 1, 1, 0);
    for (int i = 27; i <= 32; i++) tbl[i] = mk(0, 8'h00, 0, 1, 0, 0);
    tbl[33] = mk(0, 8'h00, 0, 1, 0, 1);
    tbl[34] = mk(0, 8'h00, 0, 0, 1, 1);

    for (int i = 0; i < 35; i++) begin
      in_valid = tbl[i].iv;
      pi       = tbl[i].d;
      @(posedge clk);
      model_edge(tbl[i].iv, tbl[i].d);
      #1;
      check_outs($sformatf("tbl[%0d]", i),
                 tbl[i].e_so, tbl[i].e_sov, tbl[i].e_done, tbl[i].e_rdy);
    end
`else
    // A5 has even weight -> parity 0; 07 has odd weight -> parity 1.
    cycle("par_a5_acc", 1'b1, 8'hA5);
    for (int i = 1; i <= WIDTH; i++) cycle("par_a5_bit", 1'b0, 8'h00);
    check("par_a5_parity", 32'(so), 32'd0);
    cycle("par_a5_done", 1'b0, 8'h00);
    check("par_a5_done_c10", 32'(done), 32'd1);
    cycle("par_idle", 1'b0, 8'h00);
    cycle("par_07_acc", 1'b1, 8'h07);
    for (int i = 1; i <= WIDTH; i++) cycle("par_07_bit", 1'b0, 8'h00);
    check("par_07_parity", 32'(so), 32'd1);
    cycle("par_07_done", 1'b0, 8'h00);
    check("par_07_done_c10", 32'(done), 32'd1);
`endif

    // Reset mid-frame: F0 abandoned after three bits, then 01 must come out clean.
    cycle("rf_acc_f0", 1'b1, 8'hF0);
    cycle("rf_bit1", 1'b0, 8'h00);
    cycle("rf_bit2", 1'b0, 8'h00);
    async_reset();
    cycle("rf_acc_01", 1'b1, 8'h01);
    got[0] = so;
    for (int i = 1; i < WIDTH; i++) begin
      cycle("rf_bits", 1'b0, 8'h00);
      got[i] = so;
    end
    check("rf_word_01", 32'(got), 32'h01);
    cycle("rf_tail", 1'b0, 8'h00);

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      else cycle("rand", $urandom_range(0, 99) < 70, WIDTH'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_shiftreg.md
Name: piso_shiftreg

Overview:
- Parallel-in, serial-out transmitter. It is the sending end of the serial link whose receiving end is the 8-stage serial-in shift register chain.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk cycle, LSB first.
- Flags every valid serial bit and pulses done at end of frame.
- Supports gapless back-to-back words, so a downstream serial-in chain can be fed continuously.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pi  input  WIDTH  parallel data word; sampled only on an accepted handshake.
- in_valid  input  1  pi holds a word to send.
- in_ready  output  1  block can accept a word this cycle.
- so  output  1  serial data out, registered.
- so_valid  output  1  so carries a frame bit this cycle, registered.
- done  output  1  one-cycle pulse after the final frame bit, registered.

Behaviour:
- Reset and clocking:
  - One clock, clk. rst is asynchronous and active-high.
  - While rst=1 and on release: state=IDLE, shift register=0, bit counter=0, so=0, so_valid=0, done=0, in_ready=1 (in_ready is combinational from state).
- States:
  - IDLE: in_ready=1, so=0, so_valid=0.
  - SHIFT: serialising data bits. Counter cnt (width $clog2(WIDTH+1)) indexes the bit currently on so.
- Accept: in_valid=1 and in_ready=1 at a rising edge E0. At E0: shreg<=pi, cnt<=0, state<=SHIFT.
- Output timing:
  - In the cycle following E0: so=pi[0] and so_valid=1.
  - After edge E0+k (k=0..WIDTH-1): so=pi[k].
  - Latency from accept edge to first bit is one cycle.
- in_ready during SHIFT:
  - 0 while cnt<WIDTH-1.
  - 1 during the last-bit cycle (cnt==WIDTH-1).
  - in_valid during cnt<WIDTH-1 is ignored, and pi is not sampled.
- Edge after the last-bit cycle:
  - If in_valid=1: load the new word, cnt<=0, stay in SHIFT. so carries new pi[0] with so_valid held at 1, so there is no bubble.
  - Otherwise: state<=IDLE, so<=0, so_valid<=0.
  - In both cases done=1 for exactly the one cycle following the last-bit cycle.
- Stall: so_valid never drops mid-frame. No backpressure exists on the serial side.
- Reset mid-frame: the frame is abandoned immediately (asynchronous). so_valid, so and done go to 0, and in_ready goes to 1. No partial frame resumes.
- Simultaneous rst and in_valid: rst wins and the word is not accepted.

Optional Feature:
- Macro: PISO_PARITY_EN.
- When defined:
  - Frame is WIDTH+1 bits. After pi[WIDTH-1], one even-parity bit (XOR of all WIDTH data bits, computed at load) is sent with so_valid=1.
  - in_ready rises during the parity cycle instead of the last data-bit cycle.
  - done pulses in the cycle after the parity bit.
- When undefined: frame is exactly WIDTH bits, no parity logic is instantiated, and behaviour is as above.

Test Plan:
- Reset: assert rst mid-simulation with in_valid=1 → so=0, so_valid=0, done=0, in_ready=1 immediately. No word is accepted until rst=0.
- Single word, WIDTH=8, pi=8'hA5 accepted at E0 → cycles 1..8 carry so=1,0,1,0,0,1,0,1 with so_valid=1 and in_ready=1 only in cycle 8. Cycle 9: done=1, so_valid=0, state IDLE.
- Back-to-back: 8'hA5 then 8'h3C (offered with in_valid=1 in cycle 8) → 16 consecutive so_valid=1 cycles with no gap. Serial stream is A5 LSB-first then 0,0,1,1,1,1,0,0. done=1 in cycle 9 and cycle 17.
- Ignored request: after accepting 8'hFF, hold in_valid=1 with pi=8'h00 in cycles 1..6 → in_ready=0 and so=1 throughout. The 8'h00 word is accepted only at the cycle-8 edge.
- Reset mid-frame: accept 8'hF0, assert rst after 3 bits → so_valid=0 immediately. After release, accept 8'h01 → so=1,0,0,0,0,0,0,0, with no stale 8'hF0 bits.
- PISO_PARITY_EN defined: 8'hA5 → 9-bit frame ending with parity 0. 8'h07 → frame ending with parity 1. done=1 in cycle 10 in both cases.
